task_scheduler: RTL and testbench
=================================

// Module: task_scheduler
// PURPOSE
//  PL-side mailbox controller and memory-port arbiter for the task shared memory (SMEM BRAM port B).
//  Announces PL readiness, polls the PS mailbox for a new test vector, validates CURRENT_TASK against
//  the enabled mask, and dispatches the task engine. Owns the BRAM port except while the engine runs;
//  then grants it to the engine. Signals completion via TV_OUT_READY.
// PARAMETERS
//  ADDR_W        15        BRAM word-address width (byte addr >> 2)
//  ENABLED_MASK  16'h042E  bit n set = task n implemented (tasks 1,2,3,5,10)
//  POLL_DIV      16        cycles between TV_IN_READY polls in IDLE (>=1)
//  TIMEOUT       1_000_000 max engine cycles before abort (0 = watchdog disabled)
// PORTS
//  aclk               in   1       PL fabric clock
//  aresetn            in   1       async active-low reset
//  mem_en_o           out  1       BRAM enable
//  mem_we_o           out  4       BRAM byte write enables
//  mem_addr_o         out  ADDR_W  BRAM word address
//  mem_wdata_o        out  32      BRAM write data
//  mem_rdata_i        in   32      BRAM read data, valid 1 cycle after en with we=0
//  eng_mem_en_i       in   1       engine BRAM request enable
//  eng_mem_we_i       in   4       engine byte write enables
//  eng_mem_addr_i     in   ADDR_W  engine word address
//  eng_mem_wdata_i    in   32      engine write data
//  eng_mem_rdata_o    out  32      mem_rdata_i passed through
//  task_start_o       out  1       1-cycle start pulse
//  task_id_o          out  4       task number, stable from start until done/abort
//  task_done_i        in   1       1-cycle engine completion pulse
//  busy_o             out  1       high from start pulse through completion write
//  err_unsupported_o  out  1       sticky: disabled/zero task requested
//  err_timeout_o      out  1       sticky: watchdog abort
//  err_prot_o         out  1       sticky: engine access to mailbox region blocked
// BEHAVIOUR
//  Mailbox word addrs: PL_READY 0x4000, ENABLED_TASKS 0x4001, CURRENT_TASK 0x4002, TV_IN_READY 0x4003,
//   TV_OUT_READY 0x4004. Region >= 0x4000 is mailbox; input vectors at 0x0000, outputs at 0x0200.
//  Reset: all outputs 0, state INIT_RDY, poll counter 0, sticky errors cleared.
//  FSM (one BRAM access per cycle, all writes we=4'hF):
//   INIT_RDY  write 0x4000=1                               -> INIT_EN
//   INIT_EN   write 0x4001={16'h0,ENABLED_MASK}            -> IDLE
//   IDLE      port idle; count POLL_DIV cycles             -> RD_IN
//   RD_IN     read 0x4003                                  -> WT_IN
//   WT_IN     latency cycle                                -> CHK_IN
//   CHK_IN    rdata==1 -> RD_TASK, else -> IDLE (counter reloads)
//   RD_TASK   read 0x4002 -> WT_TASK -> CHK_TASK
//   CHK_TASK  id=rdata[3:0]; rdata[31:4]==0 && id!=0 && ENABLED_MASK[id] -> CLR_IN;
//             else set err_unsupported_o -> REJ_IN
//   REJ_IN    write 0x4003=0                               -> DONE_WR (no start)
//   CLR_IN    write 0x4003=0                               -> CLR_OUT
//   CLR_OUT   write 0x4004=0; task_id_o=id                 -> DISPATCH
//   DISPATCH  task_start_o=1, busy_o=1, watchdog=0         -> RUN
//   RUN       engine owns port; watchdog counts; task_done_i -> DONE_WR;
//             watchdog==TIMEOUT-1 (TIMEOUT!=0) -> set err_timeout_o -> DONE_WR
//   DONE_WR   write 0x4004=1; busy_o falls next cycle     -> IDLE
//  Arbitration: mem_* driven by engine only in RUN; otherwise by FSM; en/we=0 in idle states.
//  Engine access with addr[ADDR_W-1:14]!=0 in RUN: mem_en_o/mem_we_o forced 0, err_prot_o set.
//  task_done_i outside RUN ignored. task_done_i in same cycle as watchdog expiry: done wins, no error.
//  Start-to-done latency is engine-defined; done-to-TV_OUT_READY write: 1 cycle.
//  Race: PS rewriting 0x4003 between CHK_IN and CLR_IN is lost (PS must not re-arm while busy).
//  Reset mid-operation: immediate return to INIT_RDY; in-flight engine access dropped; PL_READY rewritten.
// STRUCTURE
//  Package task_sched_pkg: mailbox word-address constants, state enum typedef, TASK_ID_W=4.
//  Single module; port mux kept as an always_comb in this file; no sub-module required.
// TESTING
//  Reset release -> writes 0x4000=1 then 0x4001=0x0000042E on consecutive cycles; then first read of 0x4003.
//  Preload 0x4002=3, 0x4003=1 -> 0x4003 then 0x4004 written 0; task_start_o 1 cycle, task_id_o=3;
//   done after 100 cycles -> 0x4004=1 next cycle, busy_o low after.
//  0x4002=7 (disabled), 0x4003=1 -> no start, err_unsupported_o=1, 0x4003=0, 0x4004=1.
//  TIMEOUT=1000, task 5, no done -> abort at 1000 cycles, err_timeout_o=1, 0x4004=1; late done ignored.
//  Engine write to 0x4003 during RUN -> BRAM we stays 0, err_prot_o=1; engine write to 0x0200 passes.
//  aresetn low during RUN -> all outputs 0 asynchronously; after release 0x4000=1 rewritten.

Source files
------------

// File: rtl/task_sched_pkg.sv
// Shared definitions for the PL-side task scheduler.
// Holds the mailbox word addresses, the scheduler state encoding and the
// task-validation helper used when CURRENT_TASK is checked.
package task_sched_pkg;

    // Width of the task number handed to the engine
    localparam int TASK_ID_W = 4;

    // Mailbox word addresses (byte address >> 2)
    localparam int unsigned MBOX_PL_READY      = 32'h0000_4000;
    localparam int unsigned MBOX_ENABLED_TASKS = 32'h0000_4001;
    localparam int unsigned MBOX_CURRENT_TASK  = 32'h0000_4002;
    localparam int unsigned MBOX_TV_IN_READY   = 32'h0000_4003;
    localparam int unsigned MBOX_TV_OUT_READY  = 32'h0000_4004;

    // Any word address with a bit set at or above this position is mailbox space
    localparam int MBOX_REGION_LSB = 14;

    // Scheduler states, in the order they are normally visited
    typedef enum logic [3:0] {
        ST_INIT_RDY  = 4'd0,
        ST_INIT_EN   = 4'd1,
        ST_IDLE      = 4'd2,
        ST_RD_IN     = 4'd3,
        ST_WT_IN     = 4'd4,
        ST_CHK_IN    = 4'd5,
        ST_RD_TASK   = 4'd6,
        ST_WT_TASK   = 4'd7,
        ST_CHK_TASK  = 4'd8,
        ST_REJ_IN    = 4'd9,
        ST_CLR_IN    = 4'd10,
        ST_CLR_OUT   = 4'd11,
        ST_DISPATCH  = 4'd12,
        ST_RUN       = 4'd13,
        ST_DONE_WR   = 4'd14
    } sched_state_e;

    // A CURRENT_TASK word is runnable only if it is a plain nonzero task
    // number (no stray upper bits) whose bit is set in the enabled mask.
    function automatic logic task_is_runnable(input logic [31:0] word,
                                              input logic [15:0] mask);
        logic [TASK_ID_W-1:0] id;
        id = word[TASK_ID_W-1:0];
        return (word[31:TASK_ID_W] == '0) && (id != '0) && mask[id];
    endfunction

endpackage

// File: rtl/task_scheduler.sv
// Mailbox controller and BRAM port-B arbiter for the task shared memory.
// The FSM announces PL readiness, polls TV_IN_READY, validates CURRENT_TASK,
// launches the task engine and reports completion through TV_OUT_READY.
// Port outputs owned by the FSM are registered one cycle ahead, so the
// access listed for a state is the one on the bus while in that state.
module task_scheduler
    import task_sched_pkg::*;
#(
    parameter int unsigned ADDR_W       = 15,
    parameter logic [15:0] ENABLED_MASK = 16'h042E,
    parameter int unsigned POLL_DIV     = 16,
    parameter int unsigned TIMEOUT      = 1_000_000
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    output logic                 mem_en_o,
    output logic [3:0]           mem_we_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    input  logic [31:0]          mem_rdata_i,
    input  logic                 eng_mem_en_i,
    input  logic [3:0]           eng_mem_we_i,
    input  logic [ADDR_W-1:0]    eng_mem_addr_i,
    input  logic [31:0]          eng_mem_wdata_i,
    output logic [31:0]          eng_mem_rdata_o,
    output logic                 task_start_o,
    output logic [TASK_ID_W-1:0] task_id_o,
    input  logic                 task_done_i,
    output logic                 busy_o,
    output logic                 err_unsupported_o,
    output logic                 err_timeout_o,
    output logic                 err_prot_o
);

    localparam logic [ADDR_W-1:0] A_PL_READY   = ADDR_W'(MBOX_PL_READY);
    localparam logic [ADDR_W-1:0] A_ENABLED    = ADDR_W'(MBOX_ENABLED_TASKS);
    localparam logic [ADDR_W-1:0] A_CUR_TASK   = ADDR_W'(MBOX_CURRENT_TASK);
    localparam logic [ADDR_W-1:0] A_TV_IN_RDY  = ADDR_W'(MBOX_TV_IN_READY);
    localparam logic [ADDR_W-1:0] A_TV_OUT_RDY = ADDR_W'(MBOX_TV_OUT_READY);
    localparam logic [15:0]       POLL_LAST    = 16'(POLL_DIV - 1);
    localparam logic [31:0]       WD_LAST      = 32'(TIMEOUT - 1);

    sched_state_e         state_q;
    logic                 fsmEn_q;
    logic [3:0]           fsmWe_q;
    logic [ADDR_W-1:0]    fsmAddr_q;
    logic [31:0]          fsmWdata_q;
    logic                 taskStart_q;
    logic [TASK_ID_W-1:0] taskId_q;
    logic [TASK_ID_W-1:0] pendId_q;
    logic                 busy_q;
    logic                 errUnsup_q;
    logic                 errTimeout_q;
    logic                 errProt_q;
    logic [15:0]          pollCnt_q;
    logic [31:0]          watchdog_q;

    logic                 engInMbox;
    logic                 engBlocked;

    // The engine may never touch the mailbox region; such accesses are squashed
    assign engInMbox  = (eng_mem_addr_i[ADDR_W-1:MBOX_REGION_LSB] != '0);
    assign engBlocked = eng_mem_en_i && engInMbox;

    // Scheduler FSM: sequences mailbox accesses and owns all registered outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_INIT_RDY;
            fsmEn_q      <= 1'b0;
            fsmWe_q      <= 4'h0;
            fsmAddr_q    <= '0;
            fsmWdata_q   <= '0;
            taskStart_q  <= 1'b0;
            taskId_q     <= '0;
            pendId_q     <= '0;
            busy_q       <= 1'b0;
            errUnsup_q   <= 1'b0;
            errTimeout_q <= 1'b0;
            errProt_q    <= 1'b0;
            pollCnt_q    <= '0;
            watchdog_q   <= '0;
        end else begin
            fsmEn_q     <= 1'b0;
            fsmWe_q     <= 4'h0;
            taskStart_q <= 1'b0;
            unique case (state_q)
                ST_INIT_RDY: begin
                    // First cycle out of reset issues the PL_READY write; the
                    // following cycle (write now on the bus) moves on.
                    fsmEn_q <= 1'b1;
                    fsmWe_q <= 4'hF;
                    if (!fsmEn_q) begin
                        fsmAddr_q  <= A_PL_READY;
                        fsmWdata_q <= 32'd1;
                    end else begin
                        fsmAddr_q  <= A_ENABLED;
                        fsmWdata_q <= {16'h0, ENABLED_MASK};
                        state_q    <= ST_INIT_EN;
                    end
                end
                ST_INIT_EN: begin
                    pollCnt_q <= '0;
                    state_q   <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (pollCnt_q == POLL_LAST) begin
                        pollCnt_q <= '0;
                        fsmEn_q   <= 1'b1;
                        fsmAddr_q <= A_TV_IN_RDY;
                        state_q   <= ST_RD_IN;
                    end else begin
                        pollCnt_q <= pollCnt_q + 16'd1;
                    end
                end
                ST_RD_IN:  state_q <= ST_WT_IN;
                ST_WT_IN:  state_q <= ST_CHK_IN;
                ST_CHK_IN: begin
                    if (mem_rdata_i == 32'd1) begin
                        fsmEn_q   <= 1'b1;
                        fsmAddr_q <= A_CUR_TASK;
                        state_q   <= ST_RD_TASK;
                    end else begin
                        pollCnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_RD_TASK: state_q <= ST_WT_TASK;
                ST_WT_TASK: state_q <= ST_CHK_TASK;
                ST_CHK_TASK: begin
                    fsmEn_q    <= 1'b1;
                    fsmWe_q    <= 4'hF;
                    fsmAddr_q  <= A_TV_IN_RDY;
                    fsmWdata_q <= 32'd0;
                    pendId_q   <= mem_rdata_i[TASK_ID_W-1:0];
                    if (task_is_runnable(mem_rdata_i, ENABLED_MASK)) begin
                        state_q <= ST_CLR_IN;
                    end else begin
                        errUnsup_q <= 1'b1;
                        state_q    <= ST_REJ_IN;
                    end
                end
                ST_REJ_IN: begin
                    fsmEn_q    <= 1'b1;
                    fsmWe_q    <= 4'hF;
                    fsmAddr_q  <= A_TV_OUT_RDY;
                    fsmWdata_q <= 32'd1;
                    state_q    <= ST_DONE_WR;
                end
                ST_CLR_IN: begin
                    fsmEn_q    <= 1'b1;
                    fsmWe_q    <= 4'hF;
                    fsmAddr_q  <= A_TV_OUT_RDY;
                    fsmWdata_q <= 32'd0;
                    taskId_q   <= pendId_q;
                    state_q    <= ST_CLR_OUT;
                end
                ST_CLR_OUT: begin
                    taskStart_q <= 1'b1;
                    busy_q      <= 1'b1;
                    watchdog_q  <= '0;
                    state_q     <= ST_DISPATCH;
                end
                ST_DISPATCH: state_q <= ST_RUN;
                ST_RUN: begin
                    if (engBlocked) begin
                        errProt_q <= 1'b1;
                    end
                    // Completion beats an expiring watchdog in the same cycle
                    if (task_done_i || ((TIMEOUT != 0) && (watchdog_q == WD_LAST))) begin
                        if (!task_done_i) begin
                            errTimeout_q <= 1'b1;
                        end
                        fsmEn_q    <= 1'b1;
                        fsmWe_q    <= 4'hF;
                        fsmAddr_q  <= A_TV_OUT_RDY;
                        fsmWdata_q <= 32'd1;
                        state_q    <= ST_DONE_WR;
                    end else begin
                        watchdog_q <= watchdog_q + 32'd1;
                    end
                end
                ST_DONE_WR: begin
                    busy_q    <= 1'b0;
                    pollCnt_q <= '0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_INIT_RDY;
            endcase
        end
    end

    // Port mux: the engine drives BRAM only while running, minus mailbox hits
    always_comb begin
        mem_en_o    = fsmEn_q;
        mem_we_o    = fsmWe_q;
        mem_addr_o  = fsmAddr_q;
        mem_wdata_o = fsmWdata_q;
        if (state_q == ST_RUN) begin
            mem_en_o    = eng_mem_en_i && !engBlocked;
            mem_we_o    = engBlocked ? 4'h0 : eng_mem_we_i;
            mem_addr_o  = eng_mem_addr_i;
            mem_wdata_o = eng_mem_wdata_i;
        end
    end

    assign eng_mem_rdata_o   = mem_rdata_i;
    assign task_start_o      = taskStart_q;
    assign task_id_o         = taskId_q;
    assign busy_o            = busy_q;
    assign err_unsupported_o = errUnsup_q;
    assign err_timeout_o     = errTimeout_q;
    assign err_prot_o        = errProt_q;

endmodule

// File: tb/tb_task_scheduler.sv
// Self-checking bench for task_scheduler.
// A BRAM model stands in for SMEM port B; every write the bench expects on
// the port is queued when stimulus is driven and matched in order by a
// monitor as the scheduler (or engine) produces it.
module tb_task_scheduler;

    localparam int POLL = 4;
    localparam int TMO  = 1000;

    typedef struct packed {
        logic [14:0] addr;
        logic [3:0]  we;
        logic [31:0] data;
    } wrExp_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [14:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        eng_mem_en_i = 1'b0;
    logic [3:0]  eng_mem_we_i = 4'h0;
    logic [14:0] eng_mem_addr_i = 15'h0;
    logic [31:0] eng_mem_wdata_i = 32'h0;
    logic [31:0] eng_mem_rdata_o;
    logic        task_start_o;
    logic [3:0]  task_id_o;
    logic        task_done_i = 1'b0;
    logic        busy_o;
    logic        err_unsupported_o;
    logic        err_timeout_o;
    logic        err_prot_o;

    logic [31:0] ram [0:32767] = '{default: 32'h0};
    logic        pokeEn = 1'b0;
    logic [14:0] pokeAddr = 15'h0;
    logic [31:0] pokeData = 32'h0;

    wrExp_t expQ[$];
    wrExp_t monExp;
    int     vectors = 0;
    int     miscompares = 0;

    task_scheduler #(
        .ADDR_W(15),
        .ENABLED_MASK(16'h042E),
        .POLL_DIV(POLL),
        .TIMEOUT(TMO)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .mem_en_o(mem_en_o),
        .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .eng_mem_en_i(eng_mem_en_i),
        .eng_mem_we_i(eng_mem_we_i),
        .eng_mem_addr_i(eng_mem_addr_i),
        .eng_mem_wdata_i(eng_mem_wdata_i),
        .eng_mem_rdata_o(eng_mem_rdata_o),
        .task_start_o(task_start_o),
        .task_id_o(task_id_o),
        .task_done_i(task_done_i),
        .busy_o(busy_o),
        .err_unsupported_o(err_unsupported_o),
        .err_timeout_o(err_timeout_o),
        .err_prot_o(err_prot_o)
    );

    // 100 MHz fabric clock
    always #5 aclk = ~aclk;

    // BRAM model: byte-enabled writes, one-cycle read latency, output holds
    // between reads; the PS side pokes mailbox words through the same process
    always @(posedge aclk) begin
        if (pokeEn) begin
            ram[pokeAddr] <= pokeData;
        end
        if (mem_en_o) begin
            if (mem_we_o == 4'h0) begin
                mem_rdata_i <= ram[mem_addr_o];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                end
            end
        end
    end

    // Write monitor: every BRAM write must be the next one the bench queued
    always @(negedge aclk) begin
        if (aresetn && mem_en_o && (mem_we_o != 4'h0)) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_write got addr=%h we=%h data=%h, none queued",
                         mem_addr_o, mem_we_o, mem_wdata_o);
            end else begin
                monExp = expQ.pop_front();
                if ({mem_addr_o, mem_we_o, mem_wdata_o} !== monExp) begin
                    miscompares++;
                    $display("[TB] FAIL bram_write got addr=%h we=%h data=%h, want addr=%h we=%h data=%h",
                             mem_addr_o, mem_we_o, mem_wdata_o, monExp.addr, monExp.we, monExp.data);
                end
            end
        end
    end

    // Hard stop in case some wait never returns
    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout simulation did not finish, got stuck, want finish");
        $fatal(1, "[TB] aborted");
    end

    task automatic push_write(input logic [14:0] a, input logic [31:0] d);
        expQ.push_back('{addr: a, we: 4'hF, data: d});
    endtask

    // PS-side mailbox write, applied at the next rising edge
    task automatic poke(input logic [14:0] a, input logic [31:0] d);
        @(negedge aclk);
        pokeEn = 1'b1;
        pokeAddr = a;
        pokeData = d;
        @(negedge aclk);
        pokeEn = 1'b0;
    endtask

    // Arm a test vector and queue the mailbox writes the PL should answer with
    task automatic arm_mailbox(input logic [31:0] id, input bit accept);
        push_write(15'h4003, 32'd0);
        push_write(15'h4004, accept ? 32'd0 : 32'd1);
        poke(15'h4002, id);
        poke(15'h4003, 32'd1);
    endtask

    // Bounded wait for the start pulse; returns -1 if it never comes
    task automatic wait_start(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge aclk);
            if (task_start_o) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic check_drained(input string tag);
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL %s_drain got %0d writes outstanding, want 0", tag, expQ.size());
        end
        expQ.delete();
    endtask

    // Reset values, then PL_READY / ENABLED_TASKS writes and the first poll
    task automatic test_reset();
        int first = -1;
        int second = -1;
        int rd = -1;
        logic [14:0] rdAddr = 15'h0;
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        vectors++;
        if ({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_port got en=%b we=%h addr=%h data=%h, want all 0",
                     mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o);
        end
        vectors++;
        if ({task_start_o, task_id_o, busy_o, err_unsupported_o, err_timeout_o, err_prot_o} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl got start=%b id=%h busy=%b errs=%b%b%b, want all 0",
                     task_start_o, task_id_o, busy_o, err_unsupported_o, err_timeout_o, err_prot_o);
        end
        push_write(15'h4000, 32'd1);
        push_write(15'h4001, 32'h0000_042E);
        aresetn = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge aclk);
            if (mem_en_o && mem_we_o != 4'h0) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end else if (mem_en_o && rd < 0) begin
                rd = c;
                rdAddr = mem_addr_o;
            end
        end
        vectors++;
        if (first != 1 || second != 2) begin
            miscompares++;
            $display("[TB] FAIL init_write_timing got cycles %0d,%0d, want 1,2", first, second);
        end
        vectors++;
        if (rd != 3 + POLL || rdAddr !== 15'h4003) begin
            miscompares++;
            $display("[TB] FAIL first_poll got cycle %0d addr %h, want cycle %0d addr 4003",
                     rd, rdAddr, 3 + POLL);
        end
        check_drained("reset");
    endtask

    // Task 3 dispatched, engine finishes after 100 cycles
    task automatic test_dispatch();
        int cyc;
        int enSeen = 0;
        arm_mailbox(32'd3, 1'b1);
        wait_start(cyc);
        vectors++;
        if (cyc < 0 || task_id_o !== 4'd3 || busy_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL dispatch_start got cyc=%0d id=%0d busy=%b, want start id=3 busy=1",
                     cyc, task_id_o, busy_o);
        end
        @(negedge aclk);
        vectors++;
        if (task_start_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL start_pulse_width got %b one cycle later, want 0", task_start_o);
        end
        repeat (99) begin
            @(negedge aclk);
            if (mem_en_o) enSeen++;
        end
        vectors++;
        if (enSeen != 0 || task_id_o !== 4'd3) begin
            miscompares++;
            $display("[TB] FAIL run_quiet got %0d port cycles id=%0d, want 0 and id=3", enSeen, task_id_o);
        end
        push_write(15'h4004, 32'd1);
        task_done_i = 1'b1;
        @(negedge aclk);
        task_done_i = 1'b0;
        vectors++;
        if (!(mem_en_o && mem_addr_o === 15'h4004 && busy_o === 1'b1)) begin
            miscompares++;
            $display("[TB] FAIL done_latency got en=%b addr=%h busy=%b, want en=1 addr=4004 busy=1",
                     mem_en_o, mem_addr_o, busy_o);
        end
        @(negedge aclk);
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL busy_fall got %b, want 0", busy_o);
        end
        check_drained("dispatch");
    endtask

    // Disabled task, task 0 and a word with stray upper bits are all refused
    task automatic test_unsupported();
        logic [31:0] ids [3] = '{32'd7, 32'd0, 32'h0000_0013};
        foreach (ids[k]) begin
            int starts = 0;
            int busySeen = 0;
            arm_mailbox(ids[k], 1'b0);
            repeat (40) begin
                @(negedge aclk);
                if (task_start_o) starts++;
                if (busy_o) busySeen++;
            end
            vectors++;
            if (starts != 0 || busySeen != 0) begin
                miscompares++;
                $display("[TB] FAIL reject_no_start id=%h got starts=%0d busy=%0d, want 0,0",
                         ids[k], starts, busySeen);
            end
            vectors++;
            if (err_unsupported_o !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL err_unsupported id=%h got %b, want 1", ids[k], err_unsupported_o);
            end
            check_drained("unsupported");
        end
    endtask

    // Tasks 10 then 1 re-armed immediately, each done in its first run cycle
    task automatic test_back_to_back();
        logic [3:0] ids [2] = '{4'd10, 4'd1};
        foreach (ids[k]) begin
            int cyc;
            arm_mailbox({28'h0, ids[k]}, 1'b1);
            wait_start(cyc);
            vectors++;
            if (cyc < 0 || task_id_o !== ids[k]) begin
                miscompares++;
                $display("[TB] FAIL b2b_start got cyc=%0d id=%0d, want id=%0d", cyc, task_id_o, ids[k]);
            end
            @(negedge aclk);
            push_write(15'h4004, 32'd1);
            task_done_i = 1'b1;
            @(negedge aclk);
            task_done_i = 1'b0;
            @(negedge aclk);
            vectors++;
            if (busy_o !== 1'b0 || err_timeout_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL b2b_finish got busy=%b tmo=%b, want 0,0", busy_o, err_timeout_o);
            end
        end
        check_drained("b2b");
    endtask

    // Done arriving in the final watchdog cycle completes normally
    task automatic test_done_at_expiry();
        int cyc;
        arm_mailbox(32'd5, 1'b1);
        wait_start(cyc);
        push_write(15'h4004, 32'd1);
        repeat (TMO) @(negedge aclk);
        task_done_i = 1'b1;
        @(negedge aclk);
        task_done_i = 1'b0;
        vectors++;
        if (cyc < 0 || err_timeout_o !== 1'b0 || busy_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL done_at_expiry got cyc=%0d tmo=%b busy=%b, want tmo=0 busy=1",
                     cyc, err_timeout_o, busy_o);
        end
        repeat (2) @(negedge aclk);
        check_drained("expiry");
    endtask

    // Engine writes: mailbox hit squashed and flagged, data region passes
    task automatic test_prot();
        int cyc;
        arm_mailbox(32'd2, 1'b1);
        wait_start(cyc);
        @(negedge aclk);
        @(posedge aclk);
        #1;
        eng_mem_en_i = 1'b1;
        eng_mem_we_i = 4'hF;
        eng_mem_addr_i = 15'h4003;
        eng_mem_wdata_i = 32'h0000_0055;
        #1;
        vectors++;
        if (cyc < 0 || mem_en_o !== 1'b0 || mem_we_o !== 4'h0) begin
            miscompares++;
            $display("[TB] FAIL prot_block got cyc=%0d en=%b we=%h, want en=0 we=0", cyc, mem_en_o, mem_we_o);
        end
        @(posedge aclk);
        #1;
        eng_mem_en_i = 1'b0;
        @(negedge aclk);
        vectors++;
        if (err_prot_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL err_prot got %b, want 1", err_prot_o);
        end
        push_write(15'h0200, 32'hCAFE_0001);
        @(posedge aclk);
        #1;
        eng_mem_en_i = 1'b1;
        eng_mem_addr_i = 15'h0200;
        eng_mem_wdata_i = 32'hCAFE_0001;
        @(posedge aclk);
        #1;
        eng_mem_we_i = 4'h0;
        @(posedge aclk);
        #1;
        eng_mem_en_i = 1'b0;
        #1;
        vectors++;
        if (eng_mem_rdata_o !== 32'hCAFE_0001) begin
            miscompares++;
            $display("[TB] FAIL eng_readback got %h, want cafe0001", eng_mem_rdata_o);
        end
        vectors++;
        if (ram[15'h4003] !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL mailbox_intact got TV_IN_READY=%h, want 0", ram[15'h4003]);
        end
        @(negedge aclk);
        push_write(15'h4004, 32'd1);
        task_done_i = 1'b1;
        @(negedge aclk);
        task_done_i = 1'b0;
        repeat (2) @(negedge aclk);
        check_drained("prot");
    endtask

    // Engine never answers: abort after TIMEOUT run cycles, late done ignored
    task automatic test_timeout();
        int cyc;
        int abortAt = -1;
        int enSeen = 0;
        arm_mailbox(32'd5, 1'b1);
        wait_start(cyc);
        push_write(15'h4004, 32'd1);
        for (int c = 1; c <= TMO + 100; c++) begin
            @(negedge aclk);
            if (err_timeout_o) begin
                abortAt = c;
                break;
            end
            if (mem_en_o) enSeen++;
        end
        // DISPATCH plus TIMEOUT run cycles, then the abort is visible
        vectors++;
        if (cyc < 0 || abortAt != TMO + 1 || enSeen != 0) begin
            miscompares++;
            $display("[TB] FAIL timeout_abort got cycle %0d port=%0d, want cycle %0d port=0",
                     abortAt, enSeen, TMO + 1);
        end
        vectors++;
        if (!(mem_en_o && mem_addr_o === 15'h4004 && busy_o === 1'b1)) begin
            miscompares++;
            $display("[TB] FAIL timeout_outwrite got en=%b addr=%h busy=%b, want en=1 addr=4004 busy=1",
                     mem_en_o, mem_addr_o, busy_o);
        end
        task_done_i = 1'b1;
        repeat (2) @(negedge aclk);
        task_done_i = 1'b0;
        repeat (20) @(negedge aclk);
        vectors++;
        if (busy_o !== 1'b0 || err_timeout_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL late_done got busy=%b tmo=%b, want busy=0 tmo=1", busy_o, err_timeout_o);
        end
        check_drained("timeout");
    endtask

    // Reset while the engine holds the port: outputs drop at once, init reruns
    task automatic test_reset_mid_run();
        int cyc;
        arm_mailbox(32'd1, 1'b1);
        wait_start(cyc);
        @(negedge aclk);
        @(posedge aclk);
        #1;
        eng_mem_en_i = 1'b1;
        eng_mem_we_i = 4'hF;
        eng_mem_addr_i = 15'h0300;
        eng_mem_wdata_i = 32'h1234_5678;
        aresetn = 1'b0;
        #1;
        vectors++;
        if (cyc < 0 || {mem_en_o, mem_we_o, busy_o, task_id_o, task_start_o} !== '0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_port got cyc=%0d en=%b we=%h busy=%b id=%h, want all 0",
                     cyc, mem_en_o, mem_we_o, busy_o, task_id_o);
        end
        vectors++;
        if ({err_unsupported_o, err_timeout_o, err_prot_o} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL sticky_clear got %b%b%b, want 000",
                     err_unsupported_o, err_timeout_o, err_prot_o);
        end
        eng_mem_en_i = 1'b0;
        eng_mem_we_i = 4'h0;
        repeat (2) @(negedge aclk);
        push_write(15'h4000, 32'd1);
        push_write(15'h4001, 32'h0000_042E);
        aresetn = 1'b1;
        repeat (20) @(negedge aclk);
        vectors++;
        if (ram[15'h0300] !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL dropped_access got %h at 0300, want 0", ram[15'h0300]);
        end
        check_drained("reset_mid_run");
    endtask

    // Scenario sequence; the timeout case runs after the expiry-race case
    // because err_timeout_o is sticky
    initial begin
        $display("[TB] task_scheduler bench start");
        test_reset();
        test_dispatch();
        test_unsupported();
        test_back_to_back();
        test_done_at_expiry();
        test_prot();
        test_timeout();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
